st_dram_ctrl: RTL and testbench
===============================

ST_DRAM_CTRL -- requirements
Module: st_dram_ctrl

Interface
REQ-001 SHALL have parameters: AWID_WIDTH, default 4, AXI ID width; AWADDR_WIDTH, default 10, AXI address width; WDATA_WIDTH, default 64, AXI data width.
REQ-002 SHALL use one clock and a synchronous, active-low reset; ports below, one per line: name  direction  width  meaning.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 cmd_vld  in  1  store-to-DRAM command valid.
REQ-006 cmd_rdy  out  1  command accepted when cmd_vld&cmd_rdy.
REQ-007 cmd_id  in  AWID_WIDTH  transaction ID.
REQ-008 cmd_dram_addr  in  AWADDR_WIDTH  DRAM byte address.
REQ-009 cmd_len  in  8  beats minus one.
REQ-010 cmd_oram_addr  in  12  first ORAM word address.
REQ-011 oram_rd_en  out  1  ORAM read strobe.
REQ-012 oram_rd_addr  out  12  ORAM read address.
REQ-013 oram_rd_data  in  WDATA_WIDTH  ORAM data, valid 1 cycle after oram_rd_en.
REQ-014 AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID out (AWID_WIDTH/AWADDR_WIDTH/8/3/2/1); AWREADY in 1.
REQ-015 WDATA/WSTRB/WLAST/WVALID out (WDATA_WIDTH/WDATA_WIDTH/8/1/1); WREADY in 1.
REQ-016 BID in AWID_WIDTH; BRESP in 2; BVALID in 1; BREADY out 1.
REQ-017 done_vld  out  1  one-cycle pulse, command complete.
REQ-018 done_err  out  1  valid with done_vld; 1 = BRESP!=OKAY or BID!=latched ID.

Function
REQ-019 SHALL implement FSM IDLE, AW, RD, WD, RESP; cmd_rdy = (state==IDLE), combinational.
REQ-020 IDLE: on cmd_vld&cmd_rdy latch id, addr, len, oram_addr; beat counter=0; -> AW next cycle.
REQ-021 AW: AWVALID=1, AWID/AWADDR/AWLEN from latched values, AWSIZE=3'b011, AWBURST=2'b01 (INCR); all stable while AWVALID&!AWREADY; on AWREADY -> RD.
REQ-022 RD: oram_rd_en=1 for exactly one cycle, oram_rd_addr=oram_addr+beat counter (12-bit, wraps 0xFFF->0x000); -> WD.
REQ-023 WD: capture oram_rd_data on entry cycle into WDATA register; WVALID=1 from the cycle after RD until WREADY; WSTRB=all ones; WLAST=1 iff beat counter==latched len.
REQ-024 WD with WREADY: if WLAST -> RESP, else beat counter+1 and -> RD; WDATA/WLAST stable while WVALID&!WREADY.
REQ-025 Per beat minimum latency 2 cycles (RD+WD); no W beat before AW handshake completes.
REQ-026 RESP: BREADY=1; on BVALID: done_vld=1 next cycle, done_err=(BRESP!=2'b00)|(BID!=latched id); -> IDLE.
REQ-027 New command accepted earliest the cycle after done_vld; cmd_vld outside IDLE ignored, no buffering.
REQ-028 len=0: single beat, WLAST=1 on first beat; len=255: 256 beats, counter 8-bit, no overflow.
REQ-029 BVALID/WREADY/AWREADY asserted in wrong state SHALL be ignored with no state change.
REQ-030 Exactly one outstanding burst at any time.

Reset
REQ-031 rst_n low at a clock edge: state=IDLE, AWVALID=WVALID=BREADY=WLAST=oram_rd_en=done_vld=done_err=0, WDATA=0, counters=0.
REQ-032 Reset mid-burst SHALL abandon the burst without further AXI activity; cmd_rdy=1 first cycle after reset released.

Verification
REQ-033 Single beat: id=3, addr=0x040, len=0, oram=0x010, AWREADY/WREADY/BVALID immediate, BRESP=0 -> AWLEN=0, one WLAST beat with data at 0x010, done_vld=1, done_err=0.
REQ-034 4-beat with backpressure: len=3, AWREADY low 3 cycles, WREADY low 2 cycles on beat 2 -> AW/W payload stable during stalls, oram reads 0x010..0x013 in order, WLAST only on 4th beat.
REQ-035 Error: BRESP=2'b10 -> done_err=1; BID=5 vs id=3 with BRESP=0 -> done_err=1.
REQ-036 Wrap: oram=0xFFE, len=3 -> reads 0xFFE, 0xFFF, 0x000, 0x001.
REQ-037 Max burst len=255 -> exactly 256 W beats, WLAST on beat 256, single B handshake.
REQ-038 Reset asserted during beat 2 of 4 -> all outputs 0 next cycle, cmd_rdy=1, new command completes normally.

Source files
------------

// File: rtl/st_dram_ctrl.sv
// rtl/st_dram_ctrl.sv - store-to-DRAM burst engine: ORAM reads feed one AXI write burst per command
module st_dram_ctrl #(
  parameter int AWID_WIDTH   = 4,
  parameter int AWADDR_WIDTH = 10,
  parameter int WDATA_WIDTH  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_vld,
  output logic                      cmd_rdy,
  input  logic [AWID_WIDTH-1:0]     cmd_id,
  input  logic [AWADDR_WIDTH-1:0]   cmd_dram_addr,
  input  logic [7:0]                cmd_len,
  input  logic [11:0]               cmd_oram_addr,
  output logic                      oram_rd_en,
  output logic [11:0]               oram_rd_addr,
  input  logic [WDATA_WIDTH-1:0]    oram_rd_data,
  output logic [AWID_WIDTH-1:0]     AWID,
  output logic [AWADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]                AWLEN,
  output logic [2:0]                AWSIZE,
  output logic [1:0]                AWBURST,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [WDATA_WIDTH-1:0]    WDATA,
  output logic [WDATA_WIDTH/8-1:0]  WSTRB,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [AWID_WIDTH-1:0]     BID,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  output logic                      done_vld,
  output logic                      done_err
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_RD, S_WD, S_RESP} state_t;

  state_t                    state;
  logic [AWID_WIDTH-1:0]     id_q;
  logic [AWADDR_WIDTH-1:0]   addr_q;
  logic [7:0]                len_q;
  logic [7:0]                beat;
  logic [11:0]               oram_q;
  logic [WDATA_WIDTH-1:0]    wdata_q;
  logic                      wd_first;

  assign cmd_rdy = (state == S_IDLE);
  assign AWID    = id_q;
  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = 3'b011;
  assign AWBURST = 2'b01;
  assign WSTRB   = '1;
  // ORAM data arrives in the first WD cycle; present it directly then, held copy afterwards.
  assign WDATA   = wd_first ? oram_rd_data : wdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      beat         <= '0;
      oram_q       <= '0;
      wdata_q      <= '0;
      wd_first     <= 1'b0;
      oram_rd_en   <= 1'b0;
      oram_rd_addr <= '0;
      AWVALID      <= 1'b0;
      WVALID       <= 1'b0;
      WLAST        <= 1'b0;
      BREADY       <= 1'b0;
      done_vld     <= 1'b0;
      done_err     <= 1'b0;
    end else begin
      oram_rd_en <= 1'b0;
      wd_first   <= 1'b0;
      done_vld   <= 1'b0;
      done_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_vld) begin
            id_q    <= cmd_id;
            addr_q  <= cmd_dram_addr;
            len_q   <= cmd_len;
            oram_q  <= cmd_oram_addr;
            beat    <= '0;
            AWVALID <= 1'b1;
            state   <= S_AW;
          end
        end
        S_AW: begin
          if (AWREADY) begin
            AWVALID      <= 1'b0;
            oram_rd_en   <= 1'b1;
            oram_rd_addr <= oram_q + {4'b0, beat};
            state        <= S_RD;
          end
        end
        S_RD: begin
          WVALID   <= 1'b1;
          WLAST    <= (beat == len_q);
          wd_first <= 1'b1;
          state    <= S_WD;
        end
        S_WD: begin
          if (wd_first)
            wdata_q <= oram_rd_data;
          if (WREADY) begin
            WVALID <= 1'b0;
            WLAST  <= 1'b0;
            if (WLAST) begin
              BREADY <= 1'b1;
              state  <= S_RESP;
            end else begin
              beat         <= beat + 8'd1;
              oram_rd_en   <= 1'b1;
              oram_rd_addr <= oram_q + {4'b0, beat} + 12'd1;
              state        <= S_RD;
            end
          end
        end
        S_RESP: begin
          // Stay here during the done pulse so a new command cannot overlap it.
          if (done_vld) begin
            state <= S_IDLE;
          end else if (BVALID && BREADY) begin
            BREADY   <= 1'b0;
            done_vld <= 1'b1;
            done_err <= (BRESP != 2'b00) || (BID != id_q);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_st_dram_ctrl.sv
// tb/tb_st_dram_ctrl.sv - self-checking bench for st_dram_ctrl against a burst-level reference model
module tb_st_dram_ctrl;
  localparam int IW = 4;
  localparam int AW_W = 10;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_vld;
  logic            cmd_rdy;
  logic [IW-1:0]   cmd_id;
  logic [AW_W-1:0] cmd_dram_addr;
  logic [7:0]      cmd_len;
  logic [11:0]     cmd_oram_addr;
  logic            oram_rd_en;
  logic [11:0]     oram_rd_addr;
  logic [DW-1:0]   oram_rd_data;
  logic [IW-1:0]   AWID;
  logic [AW_W-1:0] AWADDR;
  logic [7:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID;
  logic            AWREADY;
  logic [DW-1:0]   WDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;
  logic [IW-1:0]   BID;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;
  logic            done_vld;
  logic            done_err;

  always #5 clk = ~clk;

  st_dram_ctrl #(.AWID_WIDTH(IW), .AWADDR_WIDTH(AW_W), .WDATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_id(cmd_id), .cmd_dram_addr(cmd_dram_addr),
    .cmd_len(cmd_len), .cmd_oram_addr(cmd_oram_addr),
    .oram_rd_en(oram_rd_en), .oram_rd_addr(oram_rd_addr), .oram_rd_data(oram_rd_data),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .done_vld(done_vld), .done_err(done_err)
  );

  // ORAM: one-cycle read latency, garbage on the data bus when not reading
  logic [DW-1:0] mem [4096];
  always @(posedge clk)
    oram_rd_data <= oram_rd_en ? mem[oram_rd_addr] : {$urandom, $urandom};

  int n_cmp = 0;
  int n_bad = 0;

  bit rand_mode;
  int aw_stall, w_stall_beat, w_stall, abort_beat;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_vld = 1'b0;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
  endtask

  task automatic run_cmd(input logic [IW-1:0] id, input logic [AW_W-1:0] addr, input logic [7:0] len,
                         input logic [11:0] oram, input logic [1:0] bresp, input logic [IW-1:0] bid);
    int rd_cnt = 0, w_cnt = 0, b_cnt = 0, aw_cnt = 0, aw_wait = 0, w_wait = 0;
    bit done = 0, aborted = 0;
    logic [26:0] exp_aw;
    logic        exp_err;
    logic [11:0] ea;
    exp_aw  = {id, addr, len, 3'b011, 2'b01};
    exp_err = (bresp != 2'b00) || (bid != id);
    @(negedge clk);
    chk("cmd_rdy_idle", cmd_rdy, 1);
    cmd_vld = 1'b1; cmd_id = id; cmd_dram_addr = addr; cmd_len = len; cmd_oram_addr = oram;
    BID = bid; BRESP = bresp;
    @(negedge clk);
    cmd_vld = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done && !aborted; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (AWVALID) chk("aw_payload", {AWID, AWADDR, AWLEN, AWSIZE, AWBURST}, exp_aw);
      if (oram_rd_en) begin
        ea = oram + 12'(rd_cnt);
        chk("oram_addr", oram_rd_addr, ea);
        rd_cnt++;
      end
      if (WVALID) begin
        chk("w_after_aw", aw_cnt, 1);
        if (abort_beat >= 0 && w_cnt == abort_beat) begin
          idle_inputs();
          rst_n = 1'b0;
          @(negedge clk);
          chk("rst_outs", {AWVALID, WVALID, BREADY, WLAST, oram_rd_en, done_vld, done_err}, 0);
          chk("rst_wdata", WDATA, 0);
          chk("rst_rdy", cmd_rdy, 1);
          rst_n = 1'b1;
          @(negedge clk);
          chk("post_rst_quiet", {AWVALID, WVALID, oram_rd_en, BREADY}, 0);
          chk("post_rst_rdy", cmd_rdy, 1);
          aborted = 1;
        end else begin
          ea = oram + 12'(w_cnt);
          chk("w_beat", {WLAST, WDATA}, {(w_cnt == int'(len)), mem[ea]});
          chk("wstrb", WSTRB, 8'hFF);
        end
      end
      if (!aborted && done_vld) begin
        chk("done_err", done_err, exp_err);
        chk("w_count", w_cnt, int'(len) + 1);
        chk("rd_count", rd_cnt, int'(len) + 1);
        chk("b_count", b_cnt, 1);
        chk("aw_count", aw_cnt, 1);
        chk("rdy_in_done", cmd_rdy, 0);
        idle_inputs();
        @(negedge clk);
        chk("done_pulse", done_vld, 0);
        chk("rdy_after_done", cmd_rdy, 1);
        done = 1;
      end
      if (!done && !aborted) begin
        if (rand_mode) begin
          AWREADY = 1'($urandom_range(0, 1));
          WREADY  = 1'($urandom_range(0, 1));
          BVALID  = 1'($urandom_range(0, 1));
          cmd_vld = ($urandom_range(0, 3) == 0);
          cmd_id = IW'($urandom); cmd_len = 8'($urandom); cmd_oram_addr = 12'($urandom);
          cmd_dram_addr = AW_W'($urandom);
        end else begin
          AWREADY = AWVALID && (aw_wait >= aw_stall);
          if (AWVALID && !AWREADY) aw_wait++;
          WREADY = WVALID && !(w_cnt == w_stall_beat && w_wait < w_stall);
          if (WVALID && !WREADY) w_wait++;
          BVALID = BREADY;
        end
        if (AWVALID && AWREADY) aw_cnt++;
        if (WVALID && WREADY) w_cnt++;
        if (BVALID && BREADY) b_cnt++;
      end
    end
    if (!done && !aborted) chk("timeout", done, 1);
    idle_inputs();
  endtask

  initial begin
    logic [IW-1:0] rid, rbid;
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
    idle_inputs();
    cmd_id = '0; cmd_dram_addr = '0; cmd_len = '0; cmd_oram_addr = '0;
    BID = '0; BRESP = '0;
    rand_mode = 0; aw_stall = 0; w_stall_beat = -1; w_stall = 0; abort_beat = -1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {AWVALID, WVALID, BREADY, WLAST, oram_rd_en, done_vld, done_err}, 0);
    chk("reset_wdata", WDATA, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rdy", cmd_rdy, 1);

    run_cmd(4'd3, 10'h040, 8'd0, 12'h010, 2'b00, 4'd3);
    aw_stall = 3; w_stall_beat = 1; w_stall = 2;
    run_cmd(4'd3, 10'h040, 8'd3, 12'h010, 2'b00, 4'd3);
    aw_stall = 0; w_stall_beat = -1; w_stall = 0;
    run_cmd(4'd3, 10'h040, 8'd0, 12'h010, 2'b10, 4'd3);
    run_cmd(4'd3, 10'h040, 8'd0, 12'h010, 2'b00, 4'd5);
    run_cmd(4'd1, 10'h100, 8'd3, 12'hFFE, 2'b00, 4'd1);
    run_cmd(4'd2, 10'h3F8, 8'd255, 12'h123, 2'b00, 4'd2);
    abort_beat = 1;
    run_cmd(4'd4, 10'h080, 8'd3, 12'h200, 2'b00, 4'd4);
    abort_beat = -1;
    run_cmd(4'd4, 10'h080, 8'd3, 12'h200, 2'b00, 4'd4);

    rand_mode = 1;
    for (int k = 0; k < 25; k++) begin
      rid  = IW'($urandom);
      rbid = ($urandom_range(0, 3) == 0) ? IW'($urandom) : rid;
      run_cmd(rid, AW_W'($urandom), 8'($urandom_range(0, 15)), 12'($urandom),
              ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, rbid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
